// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: synchronises the PS/2 lines, deframes 11-bit frames,
// and queues good scan-code bytes in a small FIFO popped by a falling edge on rdn.
module ps2_rx_fifo #(
    parameter int DEPTH_LOG2 = 3,
    parameter int TIMEOUT    = 50000
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       rdn,
    output logic [7:0] data,
    output logic       ready,
    output logic       overflow,
    output logic       frame_err
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int TW    = $clog2(TIMEOUT + 1);
    localparam logic [DEPTH_LOG2:0] FULL_CNT   = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [TW-1:0]       TIMER_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    // [0] catches metastability, [1] is stage 1, [2] is stage 2
    logic [2:0] clk_sync_reg;
    logic [2:0] data_sync_reg;
    logic       fall_edge;
    logic       rx_bit;

    state_t          state_reg, state_next;
    logic [2:0]      bit_cnt_reg, bit_cnt_next;
    logic [7:0]      shift_reg, shift_next;
    logic            parity_reg, parity_next;
    logic [TW-1:0]   timer_reg, timer_next;
    logic            frame_err_reg;
    logic            push_req;
    logic            err_next;
    logic            timed_out;

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [DEPTH_LOG2:0]   count_reg;
    logic                  overflow_reg;
    logic                  rdn_reg;
    logic                  pop;
    logic                  full;
    logic                  accept;
    logic                  drop;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            clk_sync_reg  <= 3'b111;
            data_sync_reg <= 3'b111;
        end else begin
            clk_sync_reg  <= {clk_sync_reg[1:0], ps2_clk};
            data_sync_reg <= {data_sync_reg[1:0], ps2_data};
        end
    end

    assign fall_edge = clk_sync_reg[2] & ~clk_sync_reg[1];
    assign rx_bit    = data_sync_reg[2];

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_reg     <= ST_IDLE;
            bit_cnt_reg   <= '0;
            shift_reg     <= '0;
            parity_reg    <= 1'b0;
            timer_reg     <= '0;
            frame_err_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            bit_cnt_reg   <= bit_cnt_next;
            shift_reg     <= shift_next;
            parity_reg    <= parity_next;
            timer_reg     <= timer_next;
            frame_err_reg <= err_next;
        end
    end

    // An edge always beats the timeout, so a slow but live clock never aborts a frame
    assign timed_out = (state_reg != ST_IDLE) && !fall_edge && (timer_reg == TIMER_LAST);

    always_comb begin
        state_next   = state_reg;
        bit_cnt_next = bit_cnt_reg;
        shift_next   = shift_reg;
        parity_next  = parity_reg;
        timer_next   = (state_reg == ST_IDLE || fall_edge) ? '0 : timer_reg + 1'b1;
        push_req     = 1'b0;
        err_next     = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (fall_edge && !rx_bit) begin
                    state_next   = ST_DATA;
                    bit_cnt_next = '0;
                end
            end
            ST_DATA: begin
                if (fall_edge) begin
                    shift_next   = {rx_bit, shift_reg[7:1]};
                    bit_cnt_next = bit_cnt_reg + 1'b1;
                    if (bit_cnt_reg == 3'd7) begin
                        state_next = ST_PARITY;
                    end
                end
            end
            ST_PARITY: begin
                if (fall_edge) begin
                    parity_next = rx_bit;
                    state_next  = ST_STOP;
                end
            end
            ST_STOP: begin
                if (fall_edge) begin
                    if (rx_bit && (^{shift_reg, parity_reg})) begin
                        push_req = 1'b1;
                    end else begin
                        err_next = 1'b1;
                    end
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        if (timed_out) begin
            state_next = ST_IDLE;
            err_next   = 1'b1;
        end
    end

    assign full   = (count_reg == FULL_CNT);
    assign pop    = rdn_reg & ~rdn & ready;
    // A pop in the same cycle frees the slot the push needs
    assign accept = push_req & (~full | pop);
    assign drop   = push_req & full & ~pop;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
            rdn_reg      <= 1'b1;
        end else begin
            rdn_reg <= rdn;
            if (accept) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({accept, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
            if (drop) begin
                overflow_reg <= 1'b1;
            end else if (pop) begin
                overflow_reg <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr_reg] <= shift_reg;
        end
    end

    assign data      = mem[rd_ptr_reg];
    assign ready     = (count_reg != '0);
    assign overflow  = overflow_reg;
    assign frame_err = frame_err_reg;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Bench for ps2_rx_fifo: bit-bangs PS/2 frames (directed and random) and compares
// ready/data/overflow/frame_err against a queue-based model of the receive FIFO.
module tb_ps2_rx_fifo;

    localparam int DEPTH_LOG2 = 3;
    localparam int DEPTH      = 8;
    localparam int TIMEOUT    = 300;
    localparam int HALF       = 20;

    logic       clk = 1'b0;
    logic       clrn;
    logic       ps2_clk;
    logic       ps2_data;
    logic       rdn;
    logic [7:0] data;
    logic       ready;
    logic       overflow;
    logic       frame_err;

    int checks = 0;
    int passes = 0;
    int fe_cycles = 0;

    logic [7:0] mq[$];
    bit         m_ovf = 1'b0;

    ps2_rx_fifo #(
        .DEPTH_LOG2(DEPTH_LOG2),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk      (clk),
        .clrn     (clrn),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .rdn      (rdn),
        .data     (data),
        .ready    (ready),
        .overflow (overflow),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_err === 1'b1) fe_cycles++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic check_state(input string tag);
        check({tag, "_ready"}, 32'(ready), 32'(mq.size() != 0));
        check({tag, "_overflow"}, 32'(overflow), 32'(m_ovf));
        if (mq.size() != 0) check({tag, "_data"}, 32'(data), 32'(mq[0]));
    endtask

    function automatic logic [10:0] make_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        logic par;
        par = (~^b) ^ bad_par;
        return {~bad_stop, par, b, 1'b0};
    endfunction

    // Frame acceptance from the protocol rules: start 0, odd parity over data+parity, stop 1
    function automatic bit frame_good(input logic [10:0] f);
        int ones;
        ones = 0;
        for (int i = 1; i <= 9; i++) ones += int'(f[i]);
        return (f[0] == 1'b0) && (ones % 2 == 1) && (f[10] == 1'b1);
    endfunction

    function automatic void model_pop();
        if (mq.size() != 0) begin
            void'(mq.pop_front());
            m_ovf = 1'b0;
        end
    endfunction

    function automatic void model_push(input logic [7:0] b);
        if (mq.size() < DEPTH) mq.push_back(b);
        else m_ovf = 1'b1;
    endfunction

    // Called from a negedge; ps2_clk falls on a negedge and reaches the receiver three posedges later
    task automatic send_bits(input logic [10:0] f, input int nbits, input int half,
                             input bit lat_chk, input bit align_pop);
        for (int i = 0; i < nbits; i++) begin
            ps2_data = f[i];
            repeat (half) @(negedge clk);
            ps2_clk = 1'b0;
            if (i == nbits - 1 && (lat_chk || align_pop)) begin
                @(negedge clk);
                @(negedge clk);
                if (lat_chk) check("push_latency_before", 32'(ready), 32'd0);
                if (align_pop) rdn = 1'b0;
                @(negedge clk);
                if (lat_chk) check("push_latency_after", 32'(ready), 32'd1);
                repeat (half - 3) @(negedge clk);
            end else begin
                repeat (half) @(negedge clk);
            end
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                             input bit lat_chk, input bit align_pop, input int half);
        logic [10:0] f;
        int          fe0;
        bit          good;
        f    = make_frame(b, bad_par, bad_stop);
        good = frame_good(f);
        fe0  = fe_cycles;
        send_bits(f, 11, half, lat_chk, align_pop);
        repeat (4) @(negedge clk);
        rdn = 1'b1;
        repeat (2) @(negedge clk);
        if (align_pop) model_pop();
        if (good) model_push(b);
        $display("frame %02h par_bad=%0d stop_bad=%0d pop=%0d -> fifo=%0d ovf=%0d",
                 b, bad_par, bad_stop, align_pop, mq.size(), m_ovf);
        check("frame_err_cycles", 32'(fe_cycles - fe0), good ? 32'd0 : 32'd1);
        check_state("frame");
    endtask

    task automatic do_pop(input int hold);
        rdn = 1'b0;
        repeat (hold) @(negedge clk);
        rdn = 1'b1;
        repeat (2) @(negedge clk);
        model_pop();
        $display("pop hold=%0d -> fifo=%0d ovf=%0d", hold, mq.size(), m_ovf);
        check_state("pop");
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        int fe0;
        clrn = 1'b0; rdn = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_ready", 32'(ready), 32'd0);
        check("reset_overflow", 32'(overflow), 32'd0);
        check("reset_frame_err", 32'(frame_err), 32'd0);
        clrn = 1'b1;
        repeat (3) @(negedge clk);

        // Good frame, push latency, single pop on a held rdn
        send_byte(8'h1C, 1'b0, 1'b0, 1'b1, 1'b0, HALF);
        do_pop(5);

        // Bad parity, then bad stop
        send_byte(8'hF0, 1'b1, 1'b0, 1'b0, 1'b0, HALF);
        send_byte(8'hF0, 1'b0, 1'b1, 1'b0, 1'b0, HALF);

        // Fill, overflow, drain
        for (int i = 1; i <= 9; i++) send_byte(8'(i), 1'b0, 1'b0, 1'b0, 1'b0, HALF);
        for (int i = 0; i < 8; i++) do_pop(2);
        do_pop(1);

        // Full FIFO with a pop coinciding with the stop edge
        for (int i = 0; i < 8; i++) send_byte(8'hA0 + 8'(i), 1'b0, 1'b0, 1'b0, 1'b0, HALF);
        send_byte(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, HALF);
        for (int i = 0; i < 8; i++) do_pop(3);

        // Partial frame abandoned long enough to time out
        fe0 = fe_cycles;
        send_bits(make_frame(8'h3C, 1'b0, 1'b0), 5, HALF, 1'b0, 1'b0);
        repeat (TIMEOUT + 20) @(negedge clk);
        $display("timeout partial frame -> fifo=%0d", mq.size());
        check("timeout_frame_err", 32'(fe_cycles - fe0), 32'd1);
        check_state("timeout");
        send_byte(8'h32, 1'b0, 1'b0, 1'b0, 1'b0, HALF);
        do_pop(1);

        // Randomised traffic
        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 9) < 6)
                send_byte(8'($urandom), $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
                          1'b0, $urandom_range(0, 5) == 0, $urandom_range(12, 25));
            else
                do_pop($urandom_range(1, 4));
        end
        while (mq.size() != 0) do_pop(1);

        // Reset in the middle of a frame with bytes queued
        send_byte(8'h11, 1'b0, 1'b0, 1'b0, 1'b0, HALF);
        send_byte(8'h22, 1'b0, 1'b0, 1'b0, 1'b0, HALF);
        send_byte(8'h33, 1'b0, 1'b0, 1'b0, 1'b0, HALF);
        send_bits(make_frame(8'h7E, 1'b0, 1'b0), 4, HALF, 1'b0, 1'b0);
        ps2_data = 1'b1;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (5) @(negedge clk);
        clrn = 1'b0;
        #1;
        mq.delete();
        m_ovf = 1'b0;
        $display("reset mid-frame -> fifo=%0d", mq.size());
        check("midreset_ready", 32'(ready), 32'd0);
        check("midreset_overflow", 32'(overflow), 32'd0);
        @(negedge clk);
        ps2_clk = 1'b1;
        repeat (5) @(negedge clk);
        clrn = 1'b1;
        repeat (3) @(negedge clk);
        send_byte(8'h29, 1'b0, 1'b0, 1'b0, 1'b0, HALF);
        do_pop(2);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
